// File: rtl/oddr_tx_pkg.sv
// Shared types and constants for the ODDR transmit gearbox.
// The optional underrun counter is enabled with ODDR_TX_GEARBOX_STATUS_EN.
package oddr_tx_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    localparam int unsigned RISE_BIT       = 0;
    localparam int unsigned FALL_BIT       = 1;
    localparam int unsigned PAIR_W         = 2;
    localparam int unsigned UNDERRUN_CNT_W = 16;

    // Place word bits [1:0] onto the rise/fall roles of the DDR data pair
    function automatic logic [PAIR_W-1:0] to_pair(input logic [PAIR_W-1:0] bits);
        logic [PAIR_W-1:0] p;
        p           = '0;
        p[RISE_BIT] = bits[0];
        p[FALL_BIT] = bits[1];
        return p;
    endfunction

endpackage

// File: rtl/oddr_tx_hold.sv
// One-entry hold register: lets the next word wait while the current one shifts.
module oddr_tx_hold #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  drain,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  valid
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data  <= '0;
            valid <= 1'b0;
        end else begin
            if (load) begin
                data  <= load_data;
                valid <= 1'b1;
            end else if (drain) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/oddr_tx_gearbox.sv
// Serializes DATA_WIDTH-bit words into 2-bit pairs (LSB pair first) for the ODDR stage.
// Define ODDR_TX_GEARBOX_STATUS_EN to add the saturating underrun_cnt output.
module oddr_tx_gearbox
    import oddr_tx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter logic [1:0]  IDLE_PATTERN = 2'b00
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [DATA_WIDTH-1:0]     in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [PAIR_W-1:0]         d_out,
    output logic                      busy
`ifdef ODDR_TX_GEARBOX_STATUS_EN
    ,
    output logic [UNDERRUN_CNT_W-1:0] underrun_cnt
`endif
);

    localparam int unsigned BEATS = DATA_WIDTH / 2;
    localparam int unsigned CNT_W = (BEATS > 2) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    if (DATA_WIDTH < 4 || (DATA_WIDTH % 2) != 0) begin : g_bad_width
        $error("oddr_tx_gearbox: DATA_WIDTH must be even and >= 4");
    end

    state_e                  state_q, state_d;
    logic                    rst_done_q;
    logic [DATA_WIDTH-1:0]   sreg_q, sreg_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [PAIR_W-1:0]       dout_d;
    logic                    transfer;
    logic                    last_beat;
    logic                    hold_load;
    logic                    hold_drain;
    logic [DATA_WIDTH-1:0]   hold_data;
    logic                    hold_valid;

    assign in_ready  = rst_done_q && !hold_valid;
    assign transfer  = in_valid && in_ready;
    assign last_beat = (cnt_q == LAST_BEAT);

    oddr_tx_hold #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_hold (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (hold_load),
        .load_data (in_data),
        .drain     (hold_drain),
        .data      (hold_data),
        .valid     (hold_valid)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (transfer) state_d = SHIFT;
            SHIFT:   if (last_beat && !hold_valid && !transfer) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath control; sreg keeps only the pairs not yet placed on d_out
    always_comb begin
        sreg_d     = sreg_q;
        cnt_d      = cnt_q;
        dout_d     = d_out;
        hold_load  = 1'b0;
        hold_drain = 1'b0;
        case (state_q)
            IDLE: begin
                dout_d = IDLE_PATTERN;
                if (transfer) begin
                    sreg_d = in_data >> 2;
                    dout_d = to_pair(in_data[1:0]);
                    cnt_d  = '0;
                end
            end
            SHIFT: begin
                if (!last_beat) begin
                    sreg_d    = sreg_q >> 2;
                    dout_d    = to_pair(sreg_q[1:0]);
                    cnt_d     = CNT_W'(cnt_q + 1'b1);
                    hold_load = transfer;
                end else if (hold_valid) begin
                    sreg_d     = hold_data >> 2;
                    dout_d     = to_pair(hold_data[1:0]);
                    cnt_d      = '0;
                    hold_drain = 1'b1;
                end else if (transfer) begin
                    sreg_d = in_data >> 2;
                    dout_d = to_pair(in_data[1:0]);
                    cnt_d  = '0;
                end else begin
                    dout_d = IDLE_PATTERN;
                    cnt_d  = '0;
                end
            end
            default: dout_d = IDLE_PATTERN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_done_q <= 1'b0;
            sreg_q     <= '0;
            cnt_q      <= '0;
            d_out      <= IDLE_PATTERN;
            busy       <= 1'b0;
        end else begin
            rst_done_q <= 1'b1;
            sreg_q     <= sreg_d;
            cnt_q      <= cnt_d;
            d_out      <= dout_d;
            busy       <= (state_d == SHIFT);
        end
    end

`ifdef ODDR_TX_GEARBOX_STATUS_EN
    logic underrun;
    assign underrun = (state_q == SHIFT) && (state_d == IDLE);

    // Saturating count of SHIFT->IDLE drops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underrun_cnt <= '0;
        end else if (underrun && (underrun_cnt != {UNDERRUN_CNT_W{1'b1}})) begin
            underrun_cnt <= UNDERRUN_CNT_W'(underrun_cnt + 1'b1);
        end
    end
`endif

endmodule

// File: doc/oddr_tx_gearbox.md
# oddr_tx_gearbox

Transmit gearbox feeding the registered 2-bit data input of the output-DDR stage (DFFRE pair → O_DDR → O_BUF). It accepts DATA_WIDTH-bit words over a valid/ready handshake and emits one 2-bit pair per CLK cycle, LSB pair first. A one-word hold register lets back-to-back words stream with no idle gap. When no data is available it drives a fixed idle pattern.

## Interface
- DATA_WIDTH, 8: input word width; must be even and ≥ 4. N = DATA_WIDTH/2 beats per word.
- IDLE_PATTERN, 2'b00: value of D_OUT when no word is being shifted.
- CLK  input  1  single clock, shared with the DDR output stage.
- RST_N  input  1  asynchronous, active-low reset.
- IN_DATA  input  DATA_WIDTH  word to serialize.
- IN_VALID  input  1  IN_DATA valid.
- IN_READY  output  1  gearbox can accept a word this cycle.
- D_OUT  output  2  registered pair to the DDR data register; D_OUT[0] = rising-edge bit, D_OUT[1] = falling-edge bit.
- BUSY  output  1  registered; 1 while in SHIFT.
- UNDERRUN_CNT  output  16  present only with ODDR_TX_GEARBOX_STATUS_EN.

## Operation
- Transfer occurs on a rising CLK edge with IN_VALID && IN_READY.
- IN_READY = rst_done && !hold_valid. rst_done is a flop that is 0 in reset and 1 from the first edge after RST_N release.
- State IDLE:
  - D_OUT = IDLE_PATTERN.
  - On transfer: sreg ← IN_DATA, D_OUT ← IN_DATA[1:0], cnt ← 0, go to SHIFT.
- State SHIFT, cnt < N-1: D_OUT ← next pair of sreg, cnt++.
  - A transfer in this state writes hold. Only one word is held.
- State SHIFT, cnt == N-1 (last pair on D_OUT). Next state, in priority order:
  - hold_valid: load sreg from hold, clear hold_valid, D_OUT ← hold[1:0], cnt ← 0. IN_READY is 0 this cycle, so no transfer.
  - Otherwise, on a transfer: load directly from IN_DATA (gapless).
  - Otherwise: go to IDLE, D_OUT ← IDLE_PATTERN. This is an underrun.
- Words are never dropped or reordered.
- Sustained throughput is one word per N cycles.
- RST_N low in any state: immediately return to IDLE and clear sreg, hold_valid and cnt. A partially shifted word is discarded.

## Timing
- Reset values: D_OUT = IDLE_PATTERN, BUSY = 0, IN_READY = 0, UNDERRUN_CNT = 0.
- Latency: the first pair of an accepted word appears on D_OUT in the cycle after the accepting edge.
- Downstream DFFRE + O_DDR add their own fixed latency; this block does not account for it.
- Back-to-back streaming: the last pair of word k is followed in the very next cycle by the first pair of word k+1.
- IN_DATA may change freely when no transfer occurs.
- IN_READY is combinational from flops only. There is no path from IN_VALID to IN_READY.

## Configuration
- ODDR_TX_GEARBOX_STATUS_EN defined:
  - UNDERRUN_CNT port exists.
  - It increments, saturating at 16'hFFFF, on every SHIFT→IDLE transition.
  - Cleared only by reset.
- Not defined:
  - The port and counter are absent.
  - All other behaviour is identical.

## Structure
- Package oddr_tx_pkg holds:
  - the state enum (IDLE, SHIFT);
  - the D_OUT bit-role constants (RISE_BIT = 0, FALL_BIT = 1);
  - the underrun counter width (16).
- Sub-module oddr_tx_hold holds the one-entry hold register (data + valid, load/drain ports).
- Everything else (FSM, shift register, beat counter, status counter) lives in oddr_tx_gearbox.

## Test plan
- Reset sequence: RST_N low for 3 cycles, then released.
  - During reset: D_OUT = 00, IN_READY = 0.
  - IN_READY = 1 from the first edge after release.
- Single word, DATA_WIDTH = 8: send 0xE4.
  - D_OUT = 00, 01, 10, 11 on consecutive cycles, then IDLE_PATTERN.
  - BUSY is high for exactly 4 cycles.
- Back-to-back stream: IN_VALID held high with 0xE4 then 0x1B.
  - D_OUT = 00,01,10,11,11,10,01,00 with no gap.
  - IN_READY drops while hold is full.
- Hold collision: hold full at the last beat with IN_VALID high.
  - No transfer that cycle.
  - Held word is emitted next, and the pending word is accepted the following cycle.
  - Order is preserved.
- Mid-word reset: assert RST_N after the 2nd pair of 0xE4.
  - D_OUT goes to IDLE_PATTERN immediately, BUSY = 0.
  - The next word after release is serialized from its first pair.
- With ODDR_TX_GEARBOX_STATUS_EN: three isolated words give UNDERRUN_CNT = 3.
  - A continuous 3-word stream increments it by 1 only.
